// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encodings and blink mask constants for the stopwatch controller
package stopwatch_pkg;
  typedef enum logic [1:0] {RUN = 2'b00, PAUSED = 2'b01, ADJUST = 2'b10} state_t;
  localparam logic [3:0] MASK_MIN = 4'b1100;
  localparam logic [3:0] MASK_SEC = 4'b0011;
endpackage

// File: rtl/rise_detect.sv
// rise_detect: rising-edge detector with a configurable history value after reset
module rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic hist_q, hist_d;
  always_comb hist_d = d;
  always_ff @(posedge clk) hist_q <= rst ? RST_VAL : hist_d;
  assign rise = d & ~hist_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/adjust FSM issuing counter pulses and adjust-digit blink mask
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int BLINK_ENABLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       tick_4hz,
  input  logic       pse,
  input  logic       adj,
  input  logic       sel,
  output logic       clr,
  output logic       inc_sec,
  output logic       adj_sec,
  output logic       inc_min,
  output logic [3:0] blink_mask,
  output logic [1:0] state
);
  state_t     state_q, state_d;
  logic       pause_flag_q, pause_flag_d;
  logic       blink_phase_q, blink_phase_d;
  logic       clr_q, clr_d;
  logic       inc_sec_q, inc_sec_d;
  logic       adj_sec_q, adj_sec_d;
  logic       inc_min_q, inc_min_d;
  logic [3:0] blink_mask_q, blink_mask_d;
  logic       pse_rise, live, enter_adj, flag_n;
  rise_detect #(.RST_VAL(1'b1)) u_pse (
    .clk (clk),
    .rst (rst),
    .d   (pse),
    .rise(pse_rise)
  );
  // ticks are ignored while clr is still asserted after reset
  always_comb begin
    live          = ~clr_q;
    enter_adj     = state_q != ADJUST && adj;
    flag_n        = pause_flag_q ^ pse_rise;
    state_d       = enter_adj ? ADJUST :
                    state_q == ADJUST ? (adj ? ADJUST : flag_n ? PAUSED : RUN) :
                    pse_rise ? (state_q == RUN ? PAUSED : RUN) : state_q;
    pause_flag_d  = enter_adj ? (state_q == PAUSED) ^ pse_rise :
                    state_q == ADJUST ? flag_n : pause_flag_q;
    blink_phase_d = enter_adj ? 1'b0 : blink_phase_q ^ (state_q == ADJUST && live && tick_4hz);
    clr_d         = 1'b0;
    inc_sec_d     = live && tick_1hz && state_q == RUN;
    inc_min_d     = live && tick_2hz && state_q == ADJUST && !sel;
    adj_sec_d     = live && tick_2hz && state_q == ADJUST && sel;
    blink_mask_d  = (BLINK_ENABLE != 0 && state_d == ADJUST && blink_phase_d) ?
                    (sel ? MASK_SEC : MASK_MIN) : 4'b0000;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pause_flag_q  <= 1'b0;
      blink_phase_q <= 1'b0;
      clr_q         <= 1'b1;
      inc_sec_q     <= 1'b0;
      adj_sec_q     <= 1'b0;
      inc_min_q     <= 1'b0;
      blink_mask_q  <= 4'b0000;
    end else begin
      state_q       <= state_d;
      pause_flag_q  <= pause_flag_d;
      blink_phase_q <= blink_phase_d;
      clr_q         <= clr_d;
      inc_sec_q     <= inc_sec_d;
      adj_sec_q     <= adj_sec_d;
      inc_min_q     <= inc_min_d;
      blink_mask_q  <= blink_mask_d;
    end
  end
  assign clr        = clr_q;
  assign inc_sec    = inc_sec_q;
  assign adj_sec    = adj_sec_q;
  assign inc_min    = inc_min_q;
  assign blink_mask = blink_mask_q;
  assign state      = state_q;
endmodule
